// File: rtl/matrix_writeback.sv
// Avalon-MM write-master DMA: streams an N x N matrix from the matrix RAM to system memory.
// Build option TRANSPOSE_WB_EN: fetch column-major so memory receives the transpose.
module matrix_writeback #(
  parameter            AUTO_CLOCK_SINK_CLOCK_RATE = "-1",
  parameter int        ROW_STRIDE                 = 32,
  parameter int        FIFO_DEPTH                 = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [29:0] address,
  output logic [31:0] writedata,
  output logic        write,
  input  logic        waitrequest,
  output logic [9:0]  ram_addr,
  output logic        ram_rd,
  input  logic [31:0] ram_rdata,
  input  logic        slave_address,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  output logic        slave_waitrequest,
  output logic        irq,
  output logic [1:0]  dbg_state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam string CLK_RATE_UNUSED = AUTO_CLOCK_SINK_CLOCK_RATE;

  logic [1:0]    state_q, state_d;
  logic [29:0]   ptr_q, ptr_d, addr_q, addr_d;
  logic [4:0]    mxsize_q, mxsize_d, row_q, row_d, col_q, col_d;
  logic [9:0]    count_q, count_d, fetch_q, fetch_d;
  logic          irq_q, irq_d, rd_pend_q, rd_pend_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   fill_q, fill_d;
  logic [31:0]   fifo_q [FIFO_DEPTH];

  logic [9:0]    total;
  logic [PW+1:0] occupancy;
  logic          accept, push, busy;
  logic          unused_wdata;

  // Write handshake: a beat transfers on any rising edge where write=1 and
  // waitrequest=0; address/writedata hold their value while waitrequest=1.
  assign total     = 10'(mxsize_q) * 10'(mxsize_q);
  assign write     = (state_q == ST_RUN) && (fill_q != '0);
  assign accept    = write && !waitrequest;
  assign writedata = fifo_q[rd_ptr_q];
  assign address   = addr_q;
  assign busy      = (state_q == ST_RUN);
  assign irq       = irq_q;
  assign dbg_state_o       = state_q;
  assign slave_waitrequest = 1'b0;
  assign slave_readdata    = slave_address ? {31'd0, busy} : {22'd0, count_q};
  assign unused_wdata      = ^slave_writedata[31:30];

  // A beat leaving this cycle frees its slot, which keeps 1 beat/cycle with a 2-deep buffer.
  assign occupancy = {1'b0, fill_q} + (PW+2)'(rd_pend_q) - (PW+2)'(accept);
  assign ram_rd    = (state_q == ST_RUN) && (fetch_q < total) &&
                     (occupancy < (PW+2)'(FIFO_DEPTH));
  assign ram_addr  = 10'(32'(row_q) * ROW_STRIDE + 32'(col_q));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mxsize_d  = mxsize_q;
    count_d   = count_q;
    irq_d     = irq_q;
    addr_d    = addr_q;
    row_d     = row_q;
    col_d     = col_q;
    fetch_d   = fetch_q;
    rd_pend_d = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    push      = 1'b0;
    if (slave_read) irq_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (slave_write && !slave_address) ptr_d = {slave_writedata[29:2], 2'b00};
        if (slave_write && slave_address) begin
          mxsize_d = slave_writedata[4:0];
          count_d  = '0;
          irq_d    = 1'b0;
          addr_d   = ptr_q;
          row_d    = '0;
          col_d    = '0;
          fetch_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          fill_d   = '0;
          state_d  = (slave_writedata[4:0] == 5'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        rd_pend_d = ram_rd;
        if (ram_rd) begin
          fetch_d = fetch_q + 10'd1;
`ifdef TRANSPOSE_WB_EN
          if (row_q == mxsize_q - 5'd1) begin
            row_d = '0;
            col_d = col_q + 5'd1;
          end else begin
            row_d = row_q + 5'd1;
          end
`else
          if (col_q == mxsize_q - 5'd1) begin
            col_d = '0;
            row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
`endif
        end
        push = rd_pend_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (accept) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          addr_d   = addr_q + 30'd4;
          count_d  = count_q + 10'd1;
          if (count_q == total - 10'd1) state_d = ST_DONE;
        end
        fill_d = fill_q + (PW+1)'(push) - (PW+1)'(accept);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        irq_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      mxsize_q  <= '0;
      count_q   <= '0;
      irq_q     <= 1'b0;
      addr_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      fetch_q   <= '0;
      rd_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      mxsize_q  <= mxsize_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      fetch_q   <= fetch_d;
      rd_pend_q <= rd_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_matrix_writeback.sv
// Bench for matrix_writeback: directed scenarios plus randomized transfers against a matrix model.
module tb_matrix_writeback;

  logic        clk;
  logic        reset;
  logic [29:0] address;
  logic [31:0] writedata;
  logic        write;
  logic        waitrequest;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [31:0] ram_rdata;
  logic        slave_address;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;
  logic        irq;
  logic [1:0]  dbg_state;

  matrix_writeback dut (
    .clk(clk), .reset(reset),
    .address(address), .writedata(writedata), .write(write), .waitrequest(waitrequest),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_rdata(ram_rdata),
    .slave_address(slave_address), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_read(slave_read),
    .slave_readdata(slave_readdata), .slave_waitrequest(slave_waitrequest),
    .irq(irq), .dbg_state_o(dbg_state)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] ram_mem [1024];
  int          beats_seen = 0;
  int          write_seen = 0;
  int          rd_seen = 0;
  int          stall_n = 0;
  int          stall_left = 0;
  bit          rand_wait = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- RAM model: data valid the cycle after ram_rd ----------------
  initial begin
    logic        rd_hit;
    logic [9:0]  rd_a;
    ram_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk); #2;
      rd_hit = ram_rd;
      rd_a   = ram_addr;
      if (ram_rd) rd_seen++;
      @(posedge clk); #1;
      ram_rdata = rd_hit ? ram_mem[rd_a] : 32'hDEAD_BEEF;
    end
  end

  // ---------------- Avalon slave responder + scoreboard ----------------
  initial begin
    bit          prev_stalled;
    logic [31:0] prev_addr, prev_data;
    prev_stalled = 0;
    prev_addr    = '0;
    prev_data    = '0;
    waitrequest  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        waitrequest  = 1'b0;
        prev_stalled = 0;
        continue;
      end
      if (write) begin
        write_seen++;
        if (stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
        end else if (rand_wait && $urandom_range(0, 2) == 0) begin
          waitrequest = 1'b1;
        end else begin
          waitrequest = 1'b0;
        end
      end else begin
        waitrequest = 1'b0;
      end
      if (prev_stalled) begin
        check_eq("stall_write_held", 32'(write), 32'd1);
        check_eq("stall_addr_stable", 32'(address), prev_addr);
        check_eq("stall_data_stable", writedata, prev_data);
      end
      prev_stalled = write && waitrequest;
      prev_addr    = 32'(address);
      prev_data    = writedata;
      if (write && !waitrequest) begin
        beats_seen++;
        stall_left = stall_n;
        check_eq("beat_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check_eq("beat_addr", 32'(address), exp_addr_q.pop_front());
          check_eq("beat_data", writedata, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reg_write(input logic a, input logic [31:0] d);
    @(negedge clk);
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(negedge clk);
    slave_write     = 1'b0;
  endtask

  task automatic reg_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a;
    slave_read    = 1'b1;
    #1 d = slave_readdata;
    @(negedge clk);
    slave_read    = 1'b0;
  endtask

  // Reference: beat k of an N x N transfer
  task automatic load_expect(input logic [29:0] ptr, input int n);
    int idx;
    for (int k = 0; k < n * n; k++) begin
`ifdef TRANSPOSE_WB_EN
      idx = (k % n) * 32 + (k / n);
`else
      idx = (k / n) * 32 + (k % n);
`endif
      exp_addr_q.push_back(32'((ptr + 30'(4 * k)) & 30'h3FFF_FFFF));
      exp_q.push_back(ram_mem[idx]);
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    int cyc = 0;
    while (beats_seen < target && cyc < budget) begin
      @(negedge clk); #2;
      cyc++;
    end
    check_eq("beats_reached", 32'(beats_seen), 32'(target));
  endtask

  // Called right before the last accepting edge.
  task automatic finish_check(input int beats);
    logic [31:0] rd;
    @(negedge clk); #1;
    check_eq("write_drop_after_last", 32'(write), 32'd0);
    check_eq("irq_not_early", 32'(irq), 32'd0);
    slave_address = 1'b1;
    #1 check_eq("status_ready_done", slave_readdata, 32'd0);
    @(negedge clk); #1;
    check_eq("irq_set", 32'(irq), 32'd1);
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    reg_read(1'b0, rd);
    check_eq("count_reg", rd, 32'(beats));
    reg_read(1'b1, rd);
    check_eq("status_idle", rd, 32'd0);
    #1 check_eq("irq_cleared_by_read", 32'(irq), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] t1_tab [9];
    logic [29:0] p;
    int          n;

`ifdef TRANSPOSE_WB_EN
    t1_tab = '{32'd0, 32'd16, 32'd32, 32'd1, 32'd17, 32'd33, 32'd2, 32'd18, 32'd34};
`else
    t1_tab = '{32'd0, 32'd1, 32'd2, 32'd16, 32'd17, 32'd18, 32'd32, 32'd33, 32'd34};
`endif
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'(16 * (i / 32) + (i % 32));

    reset = 1'b0;
    slave_address = 1'b0;
    slave_write = 1'b0;
    slave_read = 1'b0;
    slave_writedata = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_address", 32'(address), 32'd0);
    check_eq("rst_writedata", writedata, 32'd0);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_rd", 32'(ram_rd), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_count", slave_readdata, 32'd0);
    check_eq("rst_slave_wait", 32'(slave_waitrequest), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed 1: 3x3 image, no stalls, first-write latency
    beats_seen = 0;
    for (int k = 0; k < 9; k++) begin
      exp_addr_q.push_back(32'h1000 + 32'(4 * k));
      exp_q.push_back(t1_tab[k]);
    end
    reg_write(1'b0, 32'h0000_1000);
    reg_write(1'b1, 32'd3);
    #1 check_eq("lat_write_c0", 32'(write), 32'd0);
    @(negedge clk); #1 check_eq("lat_write_c1", 32'(write), 32'd0);
    @(negedge clk); #1 check_eq("lat_write_c2", 32'(write), 32'd1);
    check_eq("lat_first_addr", 32'(address), 32'h1000);
    wait_beats(9, 200);
    finish_check(9);

    // Directed 2: 2x2 with 3 stall cycles on every beat
    beats_seen = 0;
    stall_n = 3;
    stall_left = 3;
    load_expect(30'h2000, 2);
    reg_write(1'b0, 32'h0000_2000);
    reg_write(1'b1, 32'd2);
    wait_beats(4, 200);
    finish_check(4);
    stall_n = 0;
    stall_left = 0;

    // Directed 3: zero size completes without traffic
    write_seen = 0;
    rd_seen = 0;
    reg_write(1'b1, 32'd0);
    @(negedge clk); #1 check_eq("len0_irq", 32'(irq), 32'd1);
    repeat (2) @(negedge clk);
    #3;
    check_eq("len0_no_write", 32'(write_seen), 32'd0);
    check_eq("len0_no_ram_rd", 32'(rd_seen), 32'd0);
    reg_read(1'b1, rd);
    check_eq("len0_status", rd, 32'd0);
    reg_read(1'b0, rd);
    check_eq("len0_count", rd, 32'd0);

    // Directed 4: register writes while busy are ignored
    beats_seen = 0;
    load_expect(30'h3000, 3);
    reg_write(1'b0, 32'h0000_3000);
    reg_write(1'b1, 32'd3);
    reg_write(1'b1, 32'd4);
    reg_write(1'b0, 32'h0000_5000);
    reg_read(1'b1, rd);
    check_eq("busy_status", rd, 32'd1);
    wait_beats(9, 200);
    finish_check(9);

    // Directed 5: reset mid-transfer, then a fresh 1x1 transfer
    beats_seen = 0;
    load_expect(30'h4000, 5);
    reg_write(1'b0, 32'h0000_4000);
    reg_write(1'b1, 32'd5);
    wait_beats(4, 200);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("abort_write_low", 32'(write), 32'd0);
    check_eq("abort_ram_rd_low", 32'(ram_rd), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    reg_read(1'b1, rd);
    check_eq("abort_status", rd, 32'd0);
    check_eq("abort_irq", 32'(irq), 32'd0);
    reg_read(1'b0, rd);
    check_eq("abort_count", rd, 32'd0);
    beats_seen = 0;
    load_expect(30'h4100, 1);
    reg_write(1'b0, 32'h0000_4100);
    reg_write(1'b1, 32'd1);
    wait_beats(1, 100);
    finish_check(1);

    // Randomized transfers: random image, size, pointer (incl. 30-bit wrap), backpressure
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] = $urandom;
      n = $urandom_range(1, 6);
      p = (it % 3 == 2) ? 30'h3FFF_FFF0 : {$urandom_range(0, 32'h0FFF_FFFF), 2'b00};
      rand_wait = (it % 2 == 1);
      beats_seen = 0;
      load_expect(p, n);
      reg_write(1'b0, {2'b11, p});
      reg_write(1'b1, {27'h7FF_FFFF, 5'(n)});
      wait_beats(n * n, 2000);
      finish_check(n * n);
    end
    rand_wait = 0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/matrix_writeback.md
Name: matrix_writeback

Overview:
Avalon-MM write-master DMA that copies an N x N matrix of 32-bit words from the on-chip matrix RAM back to system memory. It is the outbound counterpart of the determinant unit's inbound matrix DMA. The CPU programs a destination pointer and size through a 1-bit-address Avalon slave. Completion is signalled by status and a level irq.

Parameters:
AUTO_CLOCK_SINK_CLOCK_RATE, "-1", Qsys clock-rate annotation, unused in logic
ROW_STRIDE, 32, matrix RAM words per row; RAM address = row*ROW_STRIDE + col
FIFO_DEPTH, 2, prefetch buffer entries between the RAM read port and the Avalon write port (power of 2, >=2)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
address  out  30  Avalon master byte address
writedata  out  32  Avalon master write data
write  out  1  Avalon master write request
waitrequest  in  1  Avalon master stall; a beat is accepted when write=1 and waitrequest=0
ram_addr  out  10  matrix RAM read address
ram_rd  out  1  matrix RAM read strobe
ram_rdata  in  32  matrix RAM data, valid exactly 1 cycle after a ram_rd cycle
slave_address  in  1  0 = PTR/COUNT, 1 = LEN/STATUS
slave_write  in  1  CPU register write
slave_writedata  in  32  CPU write data
slave_read  in  1  CPU register read
slave_readdata  out  32  combinational read data
slave_waitrequest  out  1  tied 0; slave accesses complete in 1 cycle
irq  out  1  completion interrupt, level

Behaviour:
- Reset values: address=0, writedata=0, write=0, ram_addr=0, ram_rd=0, irq=0, ptr=0, mxsize=0, count=0, FIFO empty, state IDLE.
- Register writes: addr0 -> ptr (bits [1:0] ignored, forced 0). addr1 -> mxsize=slave_writedata[4:0], then start. Both are ignored while state != IDLE.
- Register reads: addr0 -> count (accepted beats, zero-extended). addr1 -> status (0 READY, 1 BUSY). Any slave_read clears irq on the next edge.
- States: IDLE -> (LEN write) RUN. RUN -> (last beat accepted) DONE. DONE -> IDLE next cycle, irq<=1. A LEN write with mxsize=0 goes IDLE -> DONE directly: no RAM reads, no Avalon writes, irq raised.
- Start clears count, irq, FIFO and the row/col counters. The start cycle loads address<=ptr.
- RAM fetch: issue ram_rd with ram_addr=rowcol(r,c) when occupancy (FIFO + reads in flight) < FIFO_DEPTH and fetch index < N*N. c increments, and wraps at N-1 with r+1. ram_rdata is pushed into the FIFO the following cycle.
- Write port: write=1 whenever the FIFO is non-empty in RUN. writedata=FIFO head and address=ptr+4*k, where k is the beat index. Both are held stable while waitrequest=1.
- On accept: pop, k+1, count+1. The next beat may be presented in the following cycle, giving 1 beat/cycle sustained with waitrequest=0.
- Latency: first write asserted 2 cycles after the start edge (1 fetch + 1 RAM latency).
- Address arithmetic is 30-bit and wraps modulo 2^30 without error.
- Last beat: the accepting cycle moves to DONE, and write drops to 0 on the next edge. DONE/IDLE report status READY.
- A simultaneous slave_read and irq set gives set priority (irq=1).
- Reset asserted mid-transfer: write and ram_rd deassert immediately (async), and the transfer is abandoned. A partial memory image is acceptable.

Optional Feature:
TRANSPOSE_WB_EN
- Defined: the fetch order is column-major (r increments fastest). Memory receives the transpose, so beat k = RAM[(k mod N)*ROW_STRIDE + (k div N)].
- Undefined: row-major order only. No transpose counters are synthesised.
- Address sequence and handshake are identical in both cases.

Test Plan:
- ptr=0x1000, LEN=3, RAM row r col c = 16r+c, waitrequest=0 -> 9 writes at 0x1000..0x1020, data 0,1,2,16,17,18,32,33,34. irq=1 one cycle after the last beat. count=9.
- LEN=2 with waitrequest high for 3 cycles on every beat -> address/writedata stable during each stall, exactly 4 accepts, no duplicate or dropped words.
- LEN=0 -> write never asserts, ram_rd never asserts, irq=1 within 2 cycles, status READY, count=0.
- LEN=4 during a busy LEN=3 transfer, and a PTR write while busy -> both ignored. 9 beats to the original ptr. Read of addr1 returns 1 until done, then 0. A slave_read clears irq.
- Pull reset low after beat 4 of LEN=5 -> write=0 in the same cycle. After release, status READY, irq=0, count=0. A new LEN=1 writes exactly 1 beat.
- TRANSPOSE_WB_EN defined, LEN=3, same RAM image -> data sequence 0,16,32,1,17,33,2,18,34.
